// File: rtl/thermometer_to_binary_if.sv
// Thermometer-to-binary decoder bus.
// Groups the upstream code handshake, the downstream binary handshake and
// the error-counter controls into one bundle.
//   master : the environment (drives code/valid, bin_ready, err_clear)
//   slave  : the decoder (drives therm_ready, binary_out, bubble_err,
//            bin_valid, err_count)
interface thermometer_to_binary_if #(
  parameter int BIN_W = 8
) ();
  localparam int THERM_W = 2 ** BIN_W;

  logic [THERM_W-1:0] thermometer_code;
  logic               therm_valid;
  logic               therm_ready;
  logic [BIN_W-1:0]   binary_out;
  logic               bubble_err;
  logic               bin_valid;
  logic               bin_ready;
  logic               err_clear;
  logic [15:0]        err_count;

  modport master (
    output thermometer_code, therm_valid, bin_ready, err_clear,
    input  therm_ready, binary_out, bubble_err, bin_valid, err_count
  );

  modport slave (
    input  thermometer_code, therm_valid, bin_ready, err_clear,
    output therm_ready, binary_out, bubble_err, bin_valid, err_count
  );
endinterface

// File: rtl/thermometer_to_binary.sv
// Thermometer-to-binary decoder with bubble detection.
// Two-stage valid/ready pipeline:
//   S1 (_p1) holds the one-hot "lowest zero" boundary and the malformed flag
//   S2 (_p2) holds the encoded binary value and bubble_err
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset, discards in-flight words
//   bus  : thermometer_to_binary_if.slave (code in, binary out, err counter)
module thermometer_to_binary #(
  parameter int BIN_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  thermometer_to_binary_if.slave  bus
);
  localparam int THERM_W = 2 ** BIN_W;
  localparam logic [THERM_W-1:0] ONE = THERM_W'(1);

  logic [THERM_W-1:0] onehot_d;
  logic [THERM_W-1:0] onehot_p1_q;
  logic               err_d;
  logic               err_p1_q;
  logic               vld_p1_q;
  logic [BIN_W-1:0]   bin_d;
  logic [BIN_W-1:0]   bin_p2_q;
  logic               err_p2_q;
  logic               vld_p2_q;
  logic               s1_load;
  logic               s2_load;
  logic               out_xfer;
  logic [15:0]        err_cnt_d;
  logic [15:0]        err_cnt_q;

  // Lowest zero as a one-hot vector; all-ones input yields an empty vector.
  function automatic logic [THERM_W-1:0] lowest_zero(input logic [THERM_W-1:0] c);
    return ~c & (c + ONE);
  endfunction

  // A well-formed code has all its ones contiguous from bit 0, so adding 1
  // carries through them and clears every set bit. The top bit must also be 0.
  function automatic logic malformed(input logic [THERM_W-1:0] c);
    return (|(c & (c + ONE))) | c[THERM_W-1];
  endfunction

  // One-hot to binary; an empty vector means the code was all ones.
  function automatic logic [BIN_W-1:0] encode(input logic [THERM_W-1:0] oh);
    logic [BIN_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < THERM_W; i++) begin
      if (oh[i]) idx = idx | BIN_W'(i);
    end
    if (~|oh) idx = '1;
    return idx;
  endfunction

  // Each stage accepts when empty or when its contents move on this edge.
  assign s2_load  = ~vld_p2_q | bus.bin_ready;
  assign s1_load  = ~vld_p1_q | s2_load;
  assign out_xfer = vld_p2_q & bus.bin_ready;

  assign bus.therm_ready = s1_load;
  assign bus.bin_valid   = vld_p2_q;
  assign bus.binary_out  = bin_p2_q;
  assign bus.bubble_err  = err_p2_q;
  assign bus.err_count   = err_cnt_q;

  assign onehot_d = lowest_zero(bus.thermometer_code);
  assign err_d    = malformed(bus.thermometer_code);
  assign bin_d    = encode(onehot_p1_q);

  // Clear wins over a simultaneous increment; increment saturates.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (bus.err_clear) begin
      err_cnt_d = '0;
    end else if (out_xfer && err_p2_q && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  // ---- stage boundary: input -> S1 ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q    <= 1'b0;
      onehot_p1_q <= '0;
      err_p1_q    <= 1'b0;
    end else if (s1_load) begin
      vld_p1_q <= bus.therm_valid;
      if (bus.therm_valid) begin
        onehot_p1_q <= onehot_d;
        err_p1_q    <= err_d;
      end
    end
  end

  // ---- stage boundary: S1 -> S2 ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2_q <= 1'b0;
      bin_p2_q <= '0;
      err_p2_q <= 1'b0;
    end else if (s2_load) begin
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) begin
        bin_p2_q <= bin_d;
        err_p2_q <= err_p1_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end
endmodule

// File: tb/tb_thermometer_to_binary.sv
module tb_thermometer_to_binary;
  localparam int BIN_W   = 8;
  localparam int THERM_W = 256;

  typedef struct {
    int n;
    bit e;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  thermometer_to_binary_if #(.BIN_W(BIN_W)) bus ();

  thermometer_to_binary #(.BIN_W(BIN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Observations captured on the falling edge by tick()
  bit               o_in;
  bit               o_out;
  bit               o_tr;
  logic [BIN_W-1:0] o_bin;
  logic             o_err;

  exp_t q[$];

  // Advance one cycle: sample at the falling edge, return just after the rising edge.
  task automatic tick();
    @(negedge clk);
    o_tr  = bus.therm_ready;
    o_in  = bus.therm_valid && bus.therm_ready;
    o_out = bus.bin_valid && bus.bin_ready;
    o_bin = bus.binary_out;
    o_err = bus.bubble_err;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [THERM_W-1:0] therm(input int n);
    logic [THERM_W-1:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = 1'b1;
    return v;
  endfunction

  // Reference: count of ones from bit 0 up to the first zero.
  function automatic int model_n(input logic [THERM_W-1:0] c);
    int n;
    bit run;
    n = 0;
    run = 1'b1;
    for (int i = 0; i < THERM_W; i++) begin
      if (run && c[i]) n++;
      else run = 1'b0;
    end
    if (n == THERM_W) n = THERM_W - 1;
    return n;
  endfunction

  // Reference: any one above the lowest zero, or the top bit set.
  function automatic bit model_err(input logic [THERM_W-1:0] c);
    int n;
    bit run;
    bit e;
    n = 0;
    run = 1'b1;
    e = 1'b0;
    for (int i = 0; i < THERM_W; i++) begin
      if (run && c[i]) n++;
      else begin
        run = 1'b0;
        if (c[i]) e = 1'b1;
      end
    end
    return e | c[THERM_W-1];
  endfunction

  function automatic exp_t model(input logic [THERM_W-1:0] c);
    exp_t x;
    x.n = model_n(c);
    x.e = model_err(c);
    return x;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if (bus.bin_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_bin_valid: got %b expected 0", bus.bin_valid);
    end
    n_checks++;
    if (bus.binary_out !== 8'd0) begin
      n_fail++; $display("FAIL reset_binary_out: got %0d expected 0", bus.binary_out);
    end
    n_checks++;
    if (bus.bubble_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_bubble_err: got %b expected 0", bus.bubble_err);
    end
    n_checks++;
    if (bus.err_count !== 16'h0) begin
      n_fail++; $display("FAIL reset_err_count: got %0h expected 0", bus.err_count);
    end
    n_checks++;
    if (bus.therm_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_therm_ready: got %b expected 1", bus.therm_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_stream();
    logic [THERM_W-1:0] codes[4];
    int exp_n[4];
    codes[0] = therm(0);   exp_n[0] = 0;
    codes[1] = therm(3);   exp_n[1] = 3;
    codes[2] = therm(255); exp_n[2] = 255;
    codes[3] = therm(1);   exp_n[3] = 1;
    bus.bin_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (c < 4) begin
        bus.therm_valid = 1'b1;
        bus.thermometer_code = codes[c];
      end else begin
        bus.therm_valid = 1'b0;
      end
      tick();
      if (c < 4) begin
        n_checks++;
        if (o_in !== 1'b1) begin
          n_fail++; $display("FAIL stream_accept[%0d]: got %b expected 1", c, o_in);
        end
      end
      if (c >= 2 && c < 6) begin
        n_checks++;
        if (o_out !== 1'b1 || o_bin !== 8'(exp_n[c-2]) || o_err !== 1'b0) begin
          n_fail++;
          $display("FAIL stream_out[%0d]: got vld=%b bin=%0d err=%b expected vld=1 bin=%0d err=0",
                   c - 2, o_out, o_bin, o_err, exp_n[c-2]);
        end
      end else begin
        n_checks++;
        if (o_out !== 1'b0) begin
          n_fail++; $display("FAIL stream_idle[%0d]: got vld=%b expected 0", c, o_out);
        end
      end
    end
    n_checks++;
    if (bus.err_count !== 16'd0) begin
      n_fail++; $display("FAIL stream_err_count: got %0d expected 0", bus.err_count);
    end
  endtask

  // Send one word into an empty pipe and check its decode and the counter.
  task automatic single_word(input string name, input logic [THERM_W-1:0] code,
                             input int exp_bin, input bit exp_err, input int exp_cnt);
    bit seen;
    seen = 1'b0;
    bus.bin_ready = 1'b1;
    bus.therm_valid = 1'b1;
    bus.thermometer_code = code;
    tick();
    bus.therm_valid = 1'b0;
    for (int c = 0; c < 6 && !seen; c++) begin
      tick();
      if (o_out) begin
        seen = 1'b1;
        n_checks++;
        if (o_bin !== 8'(exp_bin) || o_err !== exp_err) begin
          n_fail++;
          $display("FAIL %s_out: got bin=%0d err=%b expected bin=%0d err=%b",
                   name, o_bin, o_err, exp_bin, exp_err);
        end
      end
    end
    n_checks++;
    if (!seen) begin
      n_fail++; $display("FAIL %s_timeout: got no output expected one word", name);
    end
    n_checks++;
    if (bus.err_count !== 16'(exp_cnt)) begin
      n_fail++; $display("FAIL %s_err_count: got %0d expected %0d", name, bus.err_count, exp_cnt);
    end
  endtask

  task automatic test_bubble();
    single_word("bubble", 256'h5, 1, 1'b1, 1);
  endtask

  task automatic test_all_ones();
    single_word("all_ones", '1, 255, 1'b1, 2);
  endtask

  task automatic test_stall();
    logic [THERM_W-1:0] w[3];
    int idx;
    int got;
    exp_t x;
    w[0] = therm(7);
    w[1] = therm(20);
    w[2] = 256'h9;
    idx = 0;
    got = 0;
    q.delete();
    bus.bin_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      bus.therm_valid = 1'b1;
      bus.thermometer_code = w[idx];
      tick();
      if (o_in) begin
        q.push_back(model(w[idx]));
        idx++;
      end
      if (c >= 2) begin
        n_checks++;
        if (bus.bin_valid !== 1'b1 || o_bin !== 8'd7) begin
          n_fail++;
          $display("FAIL stall_hold[%0d]: got vld=%b bin=%0d expected vld=1 bin=7",
                   c, bus.bin_valid, o_bin);
        end
      end
    end
    n_checks++;
    if (idx !== 2) begin
      n_fail++; $display("FAIL stall_accepted: got %0d expected 2", idx);
    end
    n_checks++;
    if (o_tr !== 1'b0) begin
      n_fail++; $display("FAIL stall_therm_ready: got %b expected 0", o_tr);
    end
    bus.bin_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      bus.therm_valid = (idx < 3);
      if (idx < 3) bus.thermometer_code = w[idx];
      tick();
      if (o_in) begin
        q.push_back(model(w[idx]));
        idx++;
      end
      if (o_out) begin
        got++;
        n_checks++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL stall_extra: got bin=%0d expected no word", o_bin);
        end else begin
          x = q.pop_front();
          if (o_bin !== 8'(x.n) || o_err !== x.e) begin
            n_fail++;
            $display("FAIL stall_order: got bin=%0d err=%b expected bin=%0d err=%b",
                     o_bin, o_err, x.n, x.e);
          end
        end
      end
    end
    n_checks++;
    if (got !== 3) begin
      n_fail++; $display("FAIL stall_count: got %0d expected 3", got);
    end
    n_checks++;
    if (bus.err_count !== 16'd3) begin
      n_fail++; $display("FAIL stall_err_count: got %0d expected 3", bus.err_count);
    end
  endtask

  function automatic logic [THERM_W-1:0] rand_code();
    logic [THERM_W-1:0] v;
    case ($urandom % 4)
      0: v = therm($urandom_range(0, 255));
      1: v = '1;
      2: begin
        v = therm($urandom_range(0, 255));
        v[$urandom_range(0, 255)] ^= 1'b1;
      end
      default: for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    endcase
    return v;
  endfunction

  task automatic test_random();
    int mdl_cnt;
    exp_t x;
    q.delete();
    bus.therm_valid = 1'b0;
    bus.bin_ready = 1'b1;
    bus.err_clear = 1'b1;
    tick();
    bus.err_clear = 1'b0;
    mdl_cnt = 0;
    for (int c = 0; c < 420; c++) begin
      if (c < 400) begin
        bus.therm_valid = ($urandom % 4) != 0;
        bus.thermometer_code = rand_code();
        bus.bin_ready = ($urandom % 3) != 0;
      end else begin
        bus.therm_valid = 1'b0;
        bus.bin_ready = 1'b1;
      end
      tick();
      if (o_in) q.push_back(model(bus.thermometer_code));
      if (o_out) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL random_extra: got bin=%0d expected no word", o_bin);
        end else begin
          x = q.pop_front();
          if (x.e) mdl_cnt++;
          if (o_bin !== 8'(x.n) || o_err !== x.e) begin
            n_fail++;
            $display("FAIL random_word: got bin=%0d err=%b expected bin=%0d err=%b",
                     o_bin, o_err, x.n, x.e);
          end
        end
      end
    end
    n_checks++;
    if (q.size() != 0) begin
      n_fail++; $display("FAIL random_lost: got %0d words pending expected 0", q.size());
    end
    n_checks++;
    if (bus.err_count !== 16'(mdl_cnt)) begin
      n_fail++; $display("FAIL random_err_count: got %0d expected %0d", bus.err_count, mdl_cnt);
    end
  endtask

  task automatic test_saturate();
    int outs;
    bus.therm_valid = 1'b0;
    bus.bin_ready = 1'b1;
    bus.err_clear = 1'b1;
    tick();
    bus.err_clear = 1'b0;
    outs = 0;
    bus.therm_valid = 1'b1;
    bus.thermometer_code = 256'h5;
    for (int c = 0; c < 65600 && outs < 65535; c++) begin
      tick();
      if (o_out) outs++;
    end
    bus.therm_valid = 1'b0;
    n_checks++;
    if (bus.err_count !== 16'hFFFF) begin
      n_fail++; $display("FAIL sat_reach: got %0h expected ffff after %0d errors", bus.err_count, outs);
    end
    // Words still in flight deliver further errors; the counter must hold.
    for (int c = 0; c < 4; c++) tick();
    n_checks++;
    if (bus.err_count !== 16'hFFFF) begin
      n_fail++; $display("FAIL sat_hold: got %0h expected ffff", bus.err_count);
    end
    bus.therm_valid = 1'b1;
    bus.thermometer_code = 256'h5;
    tick();
    bus.therm_valid = 1'b0;
    tick();
    bus.err_clear = 1'b1;
    tick();
    bus.err_clear = 1'b0;
    n_checks++;
    if (o_out !== 1'b1 || o_err !== 1'b1) begin
      n_fail++; $display("FAIL clear_xfer: got vld=%b err=%b expected vld=1 err=1", o_out, o_err);
    end
    n_checks++;
    if (bus.err_count !== 16'd0) begin
      n_fail++; $display("FAIL clear_priority: got %0h expected 0", bus.err_count);
    end
  endtask

  task automatic test_reset_midflight();
    single_word("pre_rst", 256'h2, 0, 1'b1, 1);
    bus.bin_ready = 1'b0;
    bus.therm_valid = 1'b1;
    bus.thermometer_code = therm(9);
    for (int c = 0; c < 3; c++) tick();
    n_checks++;
    if (bus.bin_valid !== 1'b1 || bus.therm_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_fill: got vld=%b ready=%b expected vld=1 ready=0",
               bus.bin_valid, bus.therm_ready);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.bin_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_async_valid: got %b expected 0", bus.bin_valid);
    end
    n_checks++;
    if (bus.err_count !== 16'd0) begin
      n_fail++; $display("FAIL rst_async_count: got %0d expected 0", bus.err_count);
    end
    n_checks++;
    if (bus.therm_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_async_ready: got %b expected 1", bus.therm_ready);
    end
    bus.therm_valid = 1'b0;
    bus.bin_ready = 1'b1;
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    bus.therm_valid = 1'b1;
    bus.thermometer_code = therm(42);
    tick();
    bus.therm_valid = 1'b0;
    n_checks++;
    if (o_in !== 1'b1) begin
      n_fail++; $display("FAIL post_rst_accept: got %b expected 1", o_in);
    end
    tick();
    n_checks++;
    if (o_out !== 1'b0) begin
      n_fail++; $display("FAIL post_rst_early: got vld=%b expected 0", o_out);
    end
    tick();
    n_checks++;
    if (o_out !== 1'b1 || o_bin !== 8'd42 || o_err !== 1'b0) begin
      n_fail++;
      $display("FAIL post_rst_word: got vld=%b bin=%0d err=%b expected vld=1 bin=42 err=0",
               o_out, o_bin, o_err);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.therm_valid = 1'b0;
    bus.thermometer_code = '0;
    bus.bin_ready = 1'b1;
    bus.err_clear = 1'b0;
    test_reset();
    test_stream();
    test_bubble();
    test_all_ones();
    test_stall();
    test_random();
    test_saturate();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
